// File: rtl/dco_tune_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dco_tune_pkg
// Brief   : Shared types, constants and step-clamp helper for the DCO tuner.
// Revision: 1.0
// ============================================================================
package dco_tune_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    localparam int c_FINE_W_DEF = 6;
    localparam int c_FINE_MID   = 2 ** (c_FINE_W_DEF - 1);

    function automatic int fine_mid(input int fine_w);
        return 1 << (fine_w - 1);
    endfunction

    // Loop gain is a right shift; the result is kept inside [1, FineMid-1]
    // so every accepted report moves the code and never jumps half the bank.
    function automatic logic [31:0] clamp_step(input logic [31:0] diff,
                                               input int          shift,
                                               input int          fine_w);
        logic [31:0] s;
        logic [31:0] ceil_v;
        s      = diff >> shift;
        ceil_v = 32'(fine_mid(fine_w) - 1);
        if (s == 32'd0) begin
            s = 32'd1;
        end else if (s > ceil_v) begin
            s = ceil_v;
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dco_lock_detect.sv
`default_nettype none
// ============================================================================
// Module  : dco_lock_detect
// Brief   : Saturating count of consecutive in-range reports; drives lock flag.
// Revision: 1.0
// ============================================================================
module dco_lock_detect #(
    parameter int LockCnt = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_update,
    input  logic i_in_range,
    input  logic i_clear,
    output logic o_locked
);

    localparam int                 c_CNT_W   = $clog2(LockCnt + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(LockCnt);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_locked;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_locked <= 1'b0;
        end else if (i_clear) begin
            r_cnt    <= '0;
            r_locked <= 1'b0;
        end else if (i_update) begin
            if (i_in_range) begin
                if (r_cnt != c_CNT_MAX) begin
                    r_cnt <= r_cnt + c_ONE;
                end
                // Lock asserts on the same edge the count reaches its target.
                r_locked <= (r_cnt >= (c_CNT_MAX - c_ONE));
            end else begin
                r_cnt    <= '0;
                r_locked <= 1'b0;
            end
        end
    end

    assign o_locked = r_locked;

endmodule
`default_nettype wire

// File: rtl/dco_tune_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dco_tune_ctrl
// Brief   : Turns FLL frequency-error reports into coarse/fine DCO codes.
// Revision: 1.0
// ============================================================================
module dco_tune_ctrl
    import dco_tune_pkg::*;
#(
    parameter int DiffW        = 11,
    parameter int FineW        = c_FINE_W_DEF,
    parameter int CoarseW      = 4,
    parameter int GainShift    = 2,
    parameter int SettleCycles = 8,
    parameter int LockCnt      = 4,
    parameter int CoarseInit   = 8,
    parameter int FineInit     = c_FINE_MID
) (
    input  logic               ref_clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               freq_update,
    input  logic               freq_incr_decr,
    input  logic [DiffW-1:0]   freq_diff,
    input  logic [DiffW-1:0]   lock_range,
    output logic [CoarseW-1:0] coarse_code,
    output logic [FineW-1:0]   fine_code,
    output logic               code_valid,
    output logic               busy,
    output logic               fll_locked,
    output logic               saturated
);

    localparam int                  c_SETTLE_W   = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_LOAD = c_SETTLE_W'(SettleCycles - 1);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_ONE  = c_SETTLE_W'(1);
    localparam logic [FineW-1:0]    c_FINE_CTR   = FineW'(fine_mid(FineW));
    localparam logic [FineW-1:0]    c_FINE_MAX   = {FineW{1'b1}};
    localparam logic [CoarseW-1:0]  c_COARSE_MAX = {CoarseW{1'b1}};
    localparam logic [CoarseW-1:0]  c_COARSE_ONE = CoarseW'(1);

    state_t                  r_state;
    logic [CoarseW-1:0]      r_coarse;
    logic [FineW-1:0]        r_fine;
    logic [FineW-1:0]        r_step;
    logic                    r_dir;
    logic [c_SETTLE_W-1:0]   r_settle_cnt;
    logic                    r_code_valid;
    logic                    r_busy;
    logic                    r_saturated;

    logic                    w_accept;
    logic                    w_in_range;
    logic [FineW:0]          w_sum;
    logic signed [FineW:0]   w_dec;

    assign w_in_range = (freq_diff <= lock_range);
    assign w_accept   = enable && freq_update && (r_state == ST_IDLE);
    assign w_sum      = {1'b0, r_fine} + {1'b0, r_step};
    assign w_dec      = $signed({1'b0, r_fine}) - $signed({1'b0, r_step});

    always_ff @(posedge ref_clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_coarse     <= CoarseW'(CoarseInit);
            r_fine       <= FineW'(FineInit);
            r_step       <= '0;
            r_dir        <= 1'b0;
            r_settle_cnt <= '0;
            r_code_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_saturated  <= 1'b0;
        end else if (!enable) begin
            r_state      <= ST_IDLE;
            r_code_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_code_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (freq_update && !w_in_range) begin
                        r_step  <= FineW'(clamp_step(32'(freq_diff), GainShift, FineW));
                        r_dir   <= freq_incr_decr;
                        r_state <= ST_APPLY;
                        r_busy  <= 1'b1;
                    end
                end
                ST_APPLY: begin
                    // Fine overflow/underflow carries into coarse and re-centres
                    // fine; at a coarse end the fine code pins and flags it.
                    if (r_dir) begin
                        if (!w_sum[FineW]) begin
                            r_fine      <= w_sum[FineW-1:0];
                            r_saturated <= 1'b0;
                        end else if (r_coarse != c_COARSE_MAX) begin
                            r_coarse    <= r_coarse + c_COARSE_ONE;
                            r_fine      <= c_FINE_CTR;
                            r_saturated <= 1'b0;
                        end else begin
                            r_fine      <= c_FINE_MAX;
                            r_saturated <= 1'b1;
                        end
                    end else begin
                        if (!w_dec[FineW]) begin
                            r_fine      <= w_dec[FineW-1:0];
                            r_saturated <= 1'b0;
                        end else if (r_coarse != '0) begin
                            r_coarse    <= r_coarse - c_COARSE_ONE;
                            r_fine      <= c_FINE_CTR;
                            r_saturated <= 1'b0;
                        end else begin
                            r_fine      <= '0;
                            r_saturated <= 1'b1;
                        end
                    end
                    r_code_valid <= 1'b1;
                    r_settle_cnt <= c_SETTLE_LOAD;
                    r_state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - c_SETTLE_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    dco_lock_detect #(
        .LockCnt (LockCnt)
    ) u_lock_detect (
        .clk        (ref_clk),
        .rst_n      (reset),
        .i_update   (w_accept),
        .i_in_range (w_in_range),
        .i_clear    (!enable),
        .o_locked   (fll_locked)
    );

    assign coarse_code = r_coarse;
    assign fine_code   = r_fine;
    assign code_valid  = r_code_valid;
    assign busy        = r_busy;
    assign saturated   = r_saturated;

endmodule
`default_nettype wire

// File: tb/tb_dco_tune_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dco_tune_ctrl
// Brief   : Directed bench for dco_tune_ctrl against a cycle-level code model.
// Revision: 1.0
// ============================================================================
module tb_dco_tune_ctrl;

    localparam int SETTLE = 8;
    localparam int LOCKN  = 4;
    localparam int FMAX   = 63;
    localparam int FMID   = 32;
    localparam int CMAX   = 15;

    logic        ref_clk        = 1'b0;
    logic        reset          = 1'b0;
    logic        enable         = 1'b1;
    logic        freq_update    = 1'b0;
    logic        freq_incr_decr = 1'b0;
    logic [10:0] freq_diff      = 11'd0;
    logic [10:0] lock_range     = 11'd3;
    logic [3:0]  coarse_code;
    logic [5:0]  fine_code;
    logic        code_valid;
    logic        busy;
    logic        fll_locked;
    logic        saturated;

    int checks  = 0;
    int errors  = 0;
    bit started = 1'b0;

    // Model: codes as plain integers, busy as "cycles of blanking left".
    int m_coarse = 8, m_fine = 32, m_sat = 0, m_lk = 0, m_locked = 0;
    int m_busy = 0, m_cv = 0, m_pend = 0, m_up = 0, m_step = 0, m_settle = 0;

    dco_tune_ctrl #(
        .DiffW(11), .FineW(6), .CoarseW(4), .GainShift(2),
        .SettleCycles(8), .LockCnt(4), .CoarseInit(8), .FineInit(32)
    ) dut (
        .ref_clk        (ref_clk),
        .reset          (reset),
        .enable         (enable),
        .freq_update    (freq_update),
        .freq_incr_decr (freq_incr_decr),
        .freq_diff      (freq_diff),
        .lock_range     (lock_range),
        .coarse_code    (coarse_code),
        .fine_code      (fine_code),
        .code_valid     (code_valid),
        .busy           (busy),
        .fll_locked     (fll_locked),
        .saturated      (saturated)
    );

    always #5 ref_clk = ~ref_clk;

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic model_apply();
        int s;
        s = m_up ? (m_fine + m_step) : (m_fine - m_step);
        if (s >= 0 && s <= FMAX) begin
            m_fine = s; m_sat = 0;
        end else if (m_up && m_coarse < CMAX) begin
            m_coarse = m_coarse + 1; m_fine = FMID; m_sat = 0;
        end else if (!m_up && m_coarse > 0) begin
            m_coarse = m_coarse - 1; m_fine = FMID; m_sat = 0;
        end else begin
            m_fine = m_up ? FMAX : 0; m_sat = 1;
        end
    endtask

    initial forever begin
        @(posedge ref_clk);
        if (!reset) begin
            m_coarse = 8; m_fine = 32; m_sat = 0; m_lk = 0; m_locked = 0;
            m_busy = 0; m_cv = 0; m_pend = 0; m_settle = 0;
        end else if (!enable) begin
            m_busy = 0; m_cv = 0; m_pend = 0; m_settle = 0; m_lk = 0; m_locked = 0;
        end else begin
            m_cv = 0;
            if (m_pend != 0) begin
                model_apply();
                m_pend = 0; m_cv = 1; m_settle = SETTLE;
            end else if (m_settle > 0) begin
                m_settle = m_settle - 1;
                if (m_settle == 0) m_busy = 0;
            end else if (freq_update) begin
                if (freq_diff <= lock_range) begin
                    if (m_lk < LOCKN) m_lk = m_lk + 1;
                    m_locked = (m_lk == LOCKN) ? 1 : 0;
                end else begin
                    m_lk = 0; m_locked = 0;
                    m_step = int'(freq_diff) / 4;
                    if (m_step < 1)  m_step = 1;
                    if (m_step > 31) m_step = 31;
                    m_up = freq_incr_decr ? 1 : 0;
                    m_pend = 1; m_busy = 1;
                end
            end
        end
    end

    initial forever begin
        @(negedge ref_clk);
        if (started) begin
            chk("coarse_code", int'(coarse_code), m_coarse);
            chk("fine_code",   int'(fine_code),   m_fine);
            chk("code_valid",  int'(code_valid),  m_cv);
            chk("busy",        int'(busy),        m_busy);
            chk("fll_locked",  int'(fll_locked),  m_locked);
            chk("saturated",   int'(saturated),   m_sat);
        end
    end

    task automatic pulse(input logic up, input int d);
        @(negedge ref_clk);
        freq_update = 1'b1; freq_incr_decr = up; freq_diff = 11'(d);
        @(negedge ref_clk);
        freq_update = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 60) begin
            @(negedge ref_clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
    endtask

    task automatic upd(input logic up, input int d);
        pulse(up, d);
        wait_idle();
    endtask

    task automatic do_reset();
        @(negedge ref_clk);
        reset = 1'b0;
        @(negedge ref_clk);
        reset = 1'b1;
    endtask

    task automatic lock4(input string nm);
        @(negedge ref_clk);
        freq_update = 1'b1; freq_incr_decr = 1'b1; freq_diff = 11'd2;
        for (int i = 1; i <= 4; i++) begin
            @(negedge ref_clk);
            chk(nm, int'(fll_locked), (i == 4) ? 1 : 0);
        end
        freq_update = 1'b0;
    endtask

    initial begin
        int n, nv;
        repeat (2) @(negedge ref_clk);
        started = 1'b1;
        chk("rst_coarse", int'(coarse_code), 8);
        chk("rst_fine",   int'(fine_code),   32);
        chk("rst_busy",   int'(busy),        0);
        chk("rst_locked", int'(fll_locked),  0);
        reset = 1'b1;

        // Basic update: 2-edge latency, one code_valid, 9 busy cycles
        pulse(1'b1, 40);
        n = 0; nv = 0;
        while (busy && n < 50) begin
            n++;
            if (code_valid) nv++;
            @(negedge ref_clk);
        end
        chk("busy_len",  n, 9);
        chk("cv_pulses", nv, 1);
        chk("t1_fine",   int'(fine_code), 42);
        chk("t1_coarse", int'(coarse_code), 8);

        upd(1'b1, 72);
        chk("t2_fine60", int'(fine_code), 60);
        upd(1'b1, 40);
        chk("carry_up_coarse", int'(coarse_code), 9);
        chk("carry_up_fine",   int'(fine_code), 32);
        chk("carry_up_sat",    int'(saturated), 0);

        do_reset();
        upd(1'b0, 116);
        chk("dec_fine3", int'(fine_code), 3);
        upd(1'b0, 40);
        chk("borrow_coarse", int'(coarse_code), 7);
        chk("borrow_fine",   int'(fine_code), 32);

        // Walk to the top of the code space and saturate
        do_reset();
        for (int i = 0; i < 14; i++) upd(1'b1, 124);
        chk("top_coarse", int'(coarse_code), 15);
        upd(1'b1, 112);
        chk("top_fine60", int'(fine_code), 60);
        upd(1'b1, 40);
        chk("sat_hi_fine",   int'(fine_code), 63);
        chk("sat_hi_coarse", int'(coarse_code), 15);
        chk("sat_hi_flag",   int'(saturated), 1);
        upd(1'b0, 8);
        chk("unsat_fine", int'(fine_code), 61);
        chk("unsat_flag", int'(saturated), 0);

        // Walk to the bottom and saturate, then minimum step
        do_reset();
        for (int i = 0; i < 16; i++) upd(1'b0, 124);
        chk("bot_coarse", int'(coarse_code), 0);
        upd(1'b0, 124);
        upd(1'b0, 124);
        chk("sat_lo_fine", int'(fine_code), 0);
        chk("sat_lo_flag", int'(saturated), 1);
        @(negedge ref_clk); lock_range = 11'd0;
        upd(1'b1, 2);
        chk("min_step_fine", int'(fine_code), 1);
        @(negedge ref_clk); lock_range = 11'd3;

        // Lock acquisition and loss
        do_reset();
        lock4("lock_rise");
        chk("lock_fine_held", int'(fine_code), 32);
        pulse(1'b1, 20);
        chk("lock_lost", int'(fll_locked), 0);
        chk("lock_lost_busy", int'(busy), 1);
        wait_idle();
        chk("after_lost_fine", int'(fine_code), 37);

        // Strobes during settle are dropped; first strobe after busy falls is taken
        pulse(1'b1, 40);
        repeat (3) @(negedge ref_clk);
        pulse(1'b1, 80);
        wait_idle();
        chk("drop_fine", int'(fine_code), 47);
        freq_update = 1'b1; freq_incr_decr = 1'b1; freq_diff = 11'd40;
        @(negedge ref_clk);
        chk("accept_after_busy", int'(busy), 1);
        freq_update = 1'b0;
        wait_idle();
        chk("accept_fine", int'(fine_code), 57);

        // Reset during settle
        do_reset();
        upd(1'b1, 124);
        upd(1'b1, 124);
        chk("pre_rst_coarse", int'(coarse_code), 9);
        pulse(1'b1, 40);
        repeat (3) @(negedge ref_clk);
        reset = 1'b0;
        @(negedge ref_clk);
        chk("mid_rst_coarse", int'(coarse_code), 8);
        chk("mid_rst_fine",   int'(fine_code), 32);
        chk("mid_rst_busy",   int'(busy), 0);
        reset = 1'b1;

        // Enable low clears lock, holds codes, aborts settle
        lock4("lock_rise2");
        @(negedge ref_clk); enable = 1'b0;
        @(negedge ref_clk);
        chk("en_lo_unlock", int'(fll_locked), 0);
        enable = 1'b1;
        pulse(1'b1, 40);
        repeat (3) @(negedge ref_clk);
        enable = 1'b0; freq_update = 1'b1; freq_diff = 11'd80;
        @(negedge ref_clk);
        chk("en_lo_busy", int'(busy), 0);
        chk("en_lo_fine", int'(fine_code), 42);
        freq_update = 1'b0;
        @(negedge ref_clk);
        enable = 1'b1;
        upd(1'b1, 40);
        chk("en_resume_fine", int'(fine_code), 52);

        repeat (2) @(negedge ref_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/dco_tune_ctrl.md
Name: dco_tune_ctrl

Overview:
- Downstream consumer of the frequency-locked-loop comparator. Converts each frequency-error report (update strobe, direction, magnitude) into coarse/fine DCO tuning codes.
- Applies a shift-based loop gain and carries fine-bank overflow/underflow into the coarse bank with fine re-centring.
- Blanks further updates while the DCO settles, and declares lock after a run of in-range reports.
- Runs entirely in the ref_clk domain.

Parameters:
- DiffW, 11, width of freq_diff and lock_range.
- FineW, 6, fine code width; fine range 0..2^FineW-1.
- CoarseW, 4, coarse code width; coarse range 0..2^CoarseW-1.
- GainShift, 2, step = freq_diff >> GainShift.
- SettleCycles, 8, ref_clk cycles of update blanking after each code change; must be >= 1.
- LockCnt, 4, consecutive in-range reports required to assert fll_locked; must be >= 1.
- CoarseInit, 8, coarse code after reset.
- FineInit, 32, fine code after reset.

Ports:
- ref_clk  input  1  sole clock.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  high: loop active; low: hold codes, clear lock.
- freq_update  input  1  single-cycle strobe; a new error report is valid.
- freq_incr_decr  input  1  1 = raise DCO frequency (raise code); 0 = lower it.
- freq_diff  input  DiffW  unsigned frequency-error magnitude, sampled on freq_update.
- lock_range  input  DiffW  static lock window; a report is in range when freq_diff <= lock_range.
- coarse_code  output  CoarseW  coarse bank control.
- fine_code  output  FineW  fine bank control.
- code_valid  output  1  one-cycle pulse; codes changed this cycle.
- busy  output  1  high in APPLY and SETTLE; updates are ignored while high.
- fll_locked  output  1  lock indication.
- saturated  output  1  last applied update was clamped at a code-space end.

Behaviour:
- Reset (reset == 0 at a ref_clk edge), including mid-SETTLE:
  - state = IDLE, coarse_code = CoarseInit, fine_code = FineInit.
  - code_valid, busy, fll_locked, saturated = 0; lock counter = 0.
- FSM states: IDLE, APPLY, SETTLE. All outputs are registered.
- IDLE, with enable = 1 and freq_update = 1 on edge t:
  - In range (freq_diff <= lock_range): codes unchanged, no state change. Lock counter increments, saturating at LockCnt. fll_locked = 1 from edge t when the counter reaches LockCnt.
  - Out of range: lock counter = 0 and fll_locked = 0 at edge t. Latch step and direction; go to APPLY.
  - Step = freq_diff >> GainShift, clamped to the range [1, 2^(FineW-1)-1].
- APPLY (one cycle), updating at edge t+1:
  - Increase: sum = fine + step.
    - If sum <= 2^FineW-1: fine = sum.
    - Else if coarse < max: coarse += 1 and fine = 2^(FineW-1).
    - Else: fine = 2^FineW-1 and saturated = 1.
  - Decrease: mirror of increase. On underflow below 0 with coarse > 0: coarse -= 1 and fine = 2^(FineW-1). At coarse = 0: fine = 0 and saturated = 1.
  - saturated clears on any applied update that is not clamped.
  - code_valid = 1 for the cycle following edge t+1. New codes are visible at t+1 (2-edge latency from the sampled strobe).
  - Then go to SETTLE with the settle counter loaded to SettleCycles-1.
- SETTLE:
  - Counter decrements each cycle; at 0, return to IDLE.
  - freq_update strobes during APPLY/SETTLE are dropped, with no queuing.
  - The first strobe that can be accepted is on the edge after busy falls.
- enable = 0:
  - From any state, go to IDLE at the next edge.
  - Codes hold; lock counter and fll_locked clear; code_valid = 0.
- Simultaneous events: reset dominates enable, and enable dominates freq_update.
- Arithmetic: fine sum uses FineW+1 bits to detect overflow; the decrease path uses a signed FineW+1 difference.

Decomposition:
- Package dco_tune_pkg holds:
  - the state enum type (IDLE/APPLY/SETTLE);
  - the FineMid constant 2^(FineW-1);
  - a step clamp function (shift, floor 1, ceiling FineMid-1).
- One sub-module, dco_lock_detect: the saturating consecutive-in-range counter and fll_locked register, with inputs update, in_range and clear.

Test Plan:
- Reset with defaults, then freq_update with diff = 40, lock_range = 3, incr = 1 -> after 2 edges fine = 42, coarse = 8; code_valid one cycle; busy held for 9 cycles.
- fine = 60, coarse = 8, diff = 40, incr = 1 -> coarse = 9, fine = 32, saturated = 0. Mirror case: fine = 3, decr, diff = 40 -> coarse = 7, fine = 32.
- coarse = 15, fine = 60, diff = 40, incr -> fine = 63, coarse = 15, saturated = 1. A following decr with diff = 8 -> fine = 61, saturated = 0.
- Four updates with diff = 2, lock_range = 3 -> fll_locked rises on the 4th accept edge with codes unchanged. A following diff = 20 -> fll_locked = 0 on that edge.
- freq_update pulsed during SETTLE -> ignored, codes unchanged; the strobe on the cycle after busy falls is accepted.
- reset low mid-SETTLE (coarse = 9) -> next edge coarse = 8, fine = 32, busy = 0. enable low mid-SETTLE -> IDLE, codes held, fll_locked = 0.
